// File: rtl/busca_de_instrucoes.sv
// ---------------------------------------------------------------------------
// busca_de_instrucoes -- instruction fetch unit, write-side producer for
// fila_de_instrucoes.
//
// Streams 16-bit words from a synchronous instruction memory (1-cycle read
// latency) into the instruction queue while honouring the queue's Full flag.
// A 1-entry skid register catches the word of a read that was already in
// flight when Full rose, so nothing is dropped or duplicated.
//
// Optional build macro: BUSCA_HALT_DETECT_EN
//   defined   -> pushing a word whose opcode [15:12] equals HALT_OPCODE stops
//                fetching (Halted=1) until Reset or Redirect.
//   undefined -> no opcode check, Halted is constant 0.
//
// Ports:
//   Clock        in   system clock, rising-edge
//   Reset        in   synchronous, active-low reset
//   Full         in   queue full flag (registered in the queue)
//   Push         out  queue write strobe
//   Instrucao    out  instruction word presented to the queue
//   Mem_Rden     out  instruction memory read enable
//   Mem_Address  out  instruction memory read address (== PC)
//   Mem_Q        in   memory read data, valid the cycle after Mem_Rden
//   Redirect     in   flush + PC load pulse
//   Redirect_PC  in   new PC, sampled with Redirect
//   PC           out  current fetch address (debug)
//   Halted       out  fetch stopped by a HALT opcode
// ---------------------------------------------------------------------------
module busca_de_instrucoes #(
  parameter int unsigned        ADDR_W      = 5,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [3:0]         HALT_OPCODE = 4'b1111
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Full,
  output logic              Push,
  output logic [15:0]       Instrucao,
  output logic              Mem_Rden,
  output logic [ADDR_W-1:0] Mem_Address,
  input  logic [15:0]       Mem_Q,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_PC,
  output logic [ADDR_W-1:0] PC,
  output logic              Halted
);

`ifdef BUSCA_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] pc_q,        pc_d;
  logic              inflight_q,  inflight_d;
  logic              skid_v_q,    skid_v_d;
  logic [15:0]       skid_data_q, skid_data_d;
  logic              halted_q,    halted_d;

  // A read that lands after halt was set is dropped, never pushed or skidded.
  logic inflight_live;
  logic is_halt_op;

  always_comb begin
    inflight_live = inflight_q & ~halted_q;

    Mem_Rden    = Reset & ~Full & ~halted_q & ~Redirect;
    Instrucao   = skid_v_q ? skid_data_q : Mem_Q;
    Push        = Reset & ~Redirect & ~Full & (skid_v_q | inflight_live);
    Mem_Address = pc_q;
    PC          = pc_q;
    Halted      = HALT_EN & Reset & halted_q;

    is_halt_op  = HALT_EN & Push & (Instrucao[15:12] == HALT_OPCODE);

    pc_d        = pc_q;
    inflight_d  = 1'b0;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    halted_d    = halted_q;

    if (Redirect) begin
      pc_d     = Redirect_PC;
      skid_v_d = 1'b0;
      halted_d = 1'b0;
    end else begin
      if (Mem_Rden) begin
        pc_d       = pc_q + ADDR_W'(1);
        inflight_d = 1'b1;
      end
      // The skid can only be empty here: a read issues only when !Full,
      // which is exactly when a valid skid drains.
      if (inflight_live && Full) begin
        skid_v_d    = 1'b1;
        skid_data_d = Mem_Q;
      end else if (skid_v_q && Push) begin
        skid_v_d = 1'b0;
      end
      if (is_halt_op) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc_q        <= RESET_PC;
      inflight_q  <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      halted_q    <= halted_d;
    end
  end

endmodule
